adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares one combinational 16-bit prefix adder between NREQ requesters. Each requester presents an operand pair and carry-in over a valid/ready handshake. The block arbitrates between them, registers the winning operands into the adder's inputs, and captures the adder's sum and carry-out into a response register tagged with the requester id. It sits between client datapaths and a single adder instance, and its `add_*` ports drive that instance directly.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- IDW, 2: width of the requester id, equal to clog2(NREQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_a  in  NREQ*16  operand A; requester i uses bits [16i+15:16i].
- req_b  in  NREQ*16  operand B, packed the same way as req_a.
- req_cin  in  NREQ  per-requester carry-in.
- add_a  out  16  adder operand A, driven from the stage-1 register.
- add_b  out  16  adder operand B, driven from the stage-1 register.
- add_cin  out  1  adder carry-in, driven from the stage-1 register.
- add_sum  in  16  adder sum, combinational from add_a/add_b/add_cin.
- add_cout  in  1  adder carry-out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_sum  out  16  registered sum.
- rsp_cout  out  1  registered carry-out.
- rsp_id  out  IDW  index of the requester that issued the response.
- busy  out  1  high when stage 1 or stage 2 is occupied.

## Operation
The block is a two-stage pipeline.
- S1 holds s1_v, a, b, cin and id. It drives add_a, add_b and add_cin.
- S2 holds rsp_valid, sum, cout and id.

Pipeline control:
- adv2 = !rsp_valid | rsp_ready.
- adv1 = !s1_v | adv2.

Arbitration:
- The grant is computed combinationally over req_valid each cycle.
- req_ready[g] = adv1 & !rst for the granted index g. All other bits are 0.
- req_ready is 0 for every requester when no req_valid bit is set.
- A transfer from requester i occurs when req_valid[i] & req_ready[i].

Stage-1 update, when adv1 is high:
- s1_v is loaded with the transfer indication.
- On a transfer, the operands, cin and id are loaded from the granted requester.
- Without a transfer, the operands hold their last value and s1_v falls to 0.

Stage-2 update, when adv2 is high:
- rsp_valid <= s1_v.
- When s1_v is set, S2 loads add_sum, add_cout and the S1 id.

Stall and ordering rules:
- While rsp_valid & !rsp_ready, S2 holds and S1 holds. A full pipeline deasserts all req_ready bits.
- Responses leave in acceptance order. No result is dropped or duplicated.
- The arbiter never observes the adder output. Correctness relies on add_sum settling within one cycle from S1.

Simultaneous events:
- A response drain (rsp_ready) and a new accept in the same cycle are allowed. Throughput is 1 operation per cycle.
- A requester may hold req_valid across cycles. Once asserted, its operands must stay stable until accepted.

Reset:
- Asserting rst clears s1_v, rsp_valid, S2 data and the arbitration pointer to 0 immediately, mid-operation included.
- Any in-flight results are discarded.

Reset values: req_ready=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0, add_a=0, add_b=0, add_cin=0.

## Timing
- Latency: a transfer at edge k gives rsp_valid=1 after edge k+1, provided S2 is free. Response data appears 2 edges after acceptance.
- The data path contains no combinational path from req_* to rsp_*.
- req_ready depends combinationally on rsp_ready, rsp_valid, s1_v and req_valid.
- Sustained rate with rsp_ready held at 1 is one accept per cycle. The pipeline holds at most 2 results.
- rsp_sum, rsp_cout and rsp_id are stable while rsp_valid & !rsp_ready.

## Configuration
- ADDER_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - A pointer register ptr (IDW bits, reset 0) marks the highest-priority index.
  - Priority descends cyclically from ptr.
  - On each transfer from index g, ptr <= (g+1) mod NREQ.
  - ptr does not move when no transfer occurs.
- Undefined: fixed priority, where the lowest asserted index wins. No ptr register exists.

## Test plan
- Single op: req0 with a=0xFFFF, b=0x0001, cin=0 -> two edges later rsp_valid=1, rsp_sum=0x0000, rsp_cout=1, rsp_id=0.
- Back-to-back: req2 issues 100 random ops with rsp_ready=1 -> one accept per cycle, all sums equal to a+b+cin, ids in order.
- Contention, with the macro defined: all 4 requesters valid continuously -> grants cycle 0,1,2,3,0,…. Without the macro -> requester 0 is granted every cycle.
- Backpressure: rsp_ready=0 for 5 cycles with requests pending -> exactly 2 accepts, then req_ready=0. Responses stay stable; after release they drain in order with no loss.
- Reset mid-flight: assert rst while S1 and S2 are full -> rsp_valid, busy and req_ready are 0 before the next edge. After release, the first grant goes to requester 0.
- Carry-in: a=0x7FFF, b=0x0000, cin=1 -> rsp_sum=0x8000, rsp_cout=0.

Source files
------------

// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - request/response bundle between clients and the shared-adder arbiter
interface adder_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*16-1:0] req_a;
  logic [NREQ*16-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [15:0]        rsp_sum;
  logic               rsp_cout;
  logic [IDW-1:0]     rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
endinterface

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - two-stage arbiter sharing one 16-bit adder among NREQ requesters
// ADDER_ARB_ROUND_ROBIN_EN selects round-robin arbitration; fixed lowest-index priority otherwise.
module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  adder_arbiter_if.slave    bus,
  output logic [15:0]       add_a,
  output logic [15:0]       add_b,
  output logic              add_cin,
  input  logic [15:0]       add_sum,
  input  logic              add_cout,
  output logic              busy
);

  logic           s1_v_q,   s1_v_d;
  logic [15:0]    s1_a_q,   s1_a_d;
  logic [15:0]    s1_b_q,   s1_b_d;
  logic           s1_cin_q, s1_cin_d;
  logic [IDW-1:0] s1_id_q,  s1_id_d;
  logic           s2_v_q,   s2_v_d;
  logic [15:0]    s2_sum_q, s2_sum_d;
  logic           s2_cout_q, s2_cout_d;
  logic [IDW-1:0] s2_id_q,  s2_id_d;

  logic            adv1, adv2, xfer, gnt_any;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] ready;
  logic [15:0]     sel_a, sel_b;
  logic            sel_cin;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_hi, gnt_lo;
  logic           found_hi;

  // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    gnt_hi   = '0;
    gnt_lo   = '0;
    found_hi = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt_lo = IDW'(i);
        if (IDW'(i) >= ptr_q) begin
          gnt_hi   = IDW'(i);
          found_hi = 1'b1;
        end
      end
    end
    gnt_any = |bus.req_valid;
    gnt_id  = found_hi ? gnt_hi : gnt_lo;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(i);
      end
    end
  end
`endif

  assign adv2 = !s2_v_q | bus.rsp_ready;
  assign adv1 = !s1_v_q | adv2;
  assign xfer = gnt_any & adv1 & !rst;

  always_comb begin
    ready = '0;
    if (xfer) begin
      ready[gnt_id] = 1'b1;
    end
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_a   = bus.req_a[16*i +: 16];
        sel_b   = bus.req_b[16*i +: 16];
        sel_cin = bus.req_cin[i];
      end
    end
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_cin_d  = s1_cin_q;
    s1_id_d   = s1_id_q;
    s2_v_d    = s2_v_q;
    s2_sum_d  = s2_sum_q;
    s2_cout_d = s2_cout_q;
    s2_id_d   = s2_id_q;
    if (adv1) begin
      s1_v_d = xfer;
      if (xfer) begin
        s1_a_d   = sel_a;
        s1_b_d   = sel_b;
        s1_cin_d = sel_cin;
        s1_id_d  = gnt_id;
      end
    end
    // The adder result is captured here; it must settle within one cycle of S1.
    if (adv2) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_sum_d  = add_sum;
        s2_cout_d = add_cout;
        s2_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_cin_q  <= 1'b0;
      s1_id_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_sum_q  <= '0;
      s2_cout_q <= 1'b0;
      s2_id_q   <= '0;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_cin_q  <= s1_cin_d;
      s1_id_q   <= s1_id_d;
      s2_v_q    <= s2_v_d;
      s2_sum_q  <= s2_sum_d;
      s2_cout_q <= s2_cout_d;
      s2_id_q   <= s2_id_d;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = s2_v_q;
  assign bus.rsp_sum   = s2_sum_q;
  assign bus.rsp_cout  = s2_cout_q;
  assign bus.rsp_id    = s2_id_q;
  assign add_a         = s1_a_q;
  assign add_b         = s1_b_q;
  assign add_cin       = s1_cin_q;
  assign busy          = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - randomized self-checking bench for adder_arbiter against a queue model
module tb_adder_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adder_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus();

  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout, busy;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy)
  );

  typedef struct {
    logic [18:0] d;
    int          acc_cyc;
  } ent_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          model_ptr = 0;
  ent_t        exp_q[$];
  logic [15:0] op_a[NREQ];
  logic [15:0] op_b[NREQ];
  logic        op_c[NREQ];

  always_comb begin
    bus.req_a   = '0;
    bus.req_b   = '0;
    bus.req_cin = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[16*i +: 16] = op_a[i];
      bus.req_b[16*i +: 16] = op_b[i];
      bus.req_cin[i]        = op_c[i];
    end
  end

  function automatic int exp_grant(input logic [NREQ-1:0] v);
`ifdef ADDER_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < NREQ; k++) begin
      if (v[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      if (v[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic new_op(input int i);
    op_a[i] = 16'($urandom);
    op_b[i] = 16'($urandom);
    op_c[i] = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    model_ptr = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One cycle of the reference model: sample at negedge, advance past the edge.
  task automatic step(output logic [NREQ-1:0] ro, output logic [NREQ-1:0] re,
                      output logic [19:0] so, output logic [19:0] se, output int acc);
    int          g;
    logic [16:0] s;
    @(negedge clk);
    g  = exp_grant(bus.req_valid);
    re = '0;
    if (g >= 0 && (exp_q.size() < 2 || bus.rsp_ready)) re[g] = 1'b1;
    ro = bus.req_ready;
    so = {bus.rsp_valid, bus.rsp_cout, bus.rsp_sum, bus.rsp_id};
    se = {1'b0, 19'bx};
    if (exp_q.size() > 0 && cyc >= exp_q[0].acc_cyc + 1) begin
      se = {1'b1, exp_q[0].d};
      if (bus.rsp_ready) void'(exp_q.pop_front());
    end
    acc = -1;
    if (re != '0) begin
      s = {1'b0, op_a[g]} + {1'b0, op_b[g]} + {16'd0, op_c[g]};
      exp_q.push_back('{d: {s, IDW'(g)}, acc_cyc: cyc + 1});
      model_ptr = (g + 1) % NREQ;
      acc = g;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (acc >= 0) new_op(acc);
  endtask

  task automatic test_reset();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) new_op(i);
    #1 rst = 1'b1;
    bus.req_valid = '1;
    exp_q.delete();
    model_ptr = 0;
    #1;
    tests++;
    if ({bus.req_ready, bus.rsp_valid, busy} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: got ready=%b rsp_valid=%b busy=%b expected all 0", bus.req_ready, bus.rsp_valid, busy);
    end
    @(posedge clk);
    #1;
    tests++;
    if ({bus.rsp_sum, bus.rsp_cout, bus.rsp_id, add_a, add_b, add_cin} !== '0) begin
      fails++;
      $display("FAIL reset_data: got sum=%h cout=%b id=%h a=%h b=%h cin=%b expected 0", bus.rsp_sum, bus.rsp_cout, bus.rsp_id, add_a, add_b, add_cin);
    end
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single(input int id, input logic [15:0] a, input logic [15:0] b,
                             input logic c, input logic [18:0] want, input string nm);
    logic [NREQ-1:0] ro, re, onehot;
    logic [19:0]     so, se;
    int              acc;
    op_a[id] = a;
    op_b[id] = b;
    op_c[id] = c;
    onehot = '0;
    onehot[id] = 1'b1;
    bus.req_valid = onehot;
    bus.rsp_ready = 1'b1;
    step(ro, re, so, se, acc);
    bus.req_valid = '0;
    tests++;
    if (ro !== onehot) begin
      fails++;
      $display("FAIL %s_grant: got %b expected %b", nm, ro, onehot);
    end
    step(ro, re, so, se, acc);
    tests++;
    if (so[19] !== 1'b0) begin
      fails++;
      $display("FAIL %s_early: got rsp_valid=%b expected 0", nm, so[19]);
    end
    step(ro, re, so, se, acc);
    tests++;
    if (so !== {1'b1, want}) begin
      fails++;
      $display("FAIL %s_rsp: got %h expected %h", nm, so, {1'b1, want});
    end
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] ro, re;
    logic [19:0]     so, se;
    int              acc, nacc, npop;
    nacc = 0;
    npop = 0;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    new_op(2);
    for (int n = 0; n < 100; n++) begin
      step(ro, re, so, se, acc);
      if (acc >= 0) nacc++;
      if (se[19]) npop++;
      tests++;
      if (ro !== 4'b0100) begin
        fails++;
        $display("FAIL b2b_ready: cycle %0d got %b expected 0100", n, ro);
      end
      tests++;
      if (so[19] !== se[19] || (se[19] && so[18:0] !== se[18:0])) begin
        fails++;
        $display("FAIL b2b_rsp: cycle %0d got %h expected %h", n, so, se);
      end
    end
    bus.req_valid = '0;
    for (int n = 0; n < 4; n++) begin
      step(ro, re, so, se, acc);
      if (se[19]) npop++;
      tests++;
      if (so[19] !== se[19] || (se[19] && so[18:0] !== se[18:0])) begin
        fails++;
        $display("FAIL b2b_drain: got %h expected %h", so, se);
      end
    end
    tests++;
    if (nacc != 100 || npop != 100) begin
      fails++;
      $display("FAIL b2b_count: got accepts=%0d responses=%0d expected 100/100", nacc, npop);
    end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] ro, re, want;
    logic [19:0]     so, se;
    int              acc;
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    for (int n = 0; n < 12; n++) begin
      step(ro, re, so, se, acc);
      want = '0;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
      want[n % NREQ] = 1'b1;
`else
      want[0] = 1'b1;
`endif
      tests++;
      if (ro !== want || re !== want) begin
        fails++;
        $display("FAIL contention_grant: cycle %0d got %b expected %b", n, ro, want);
      end
      tests++;
      if (so[19] !== se[19] || (se[19] && so[18:0] !== se[18:0])) begin
        fails++;
        $display("FAIL contention_rsp: got %h expected %h", so, se);
      end
    end
    bus.req_valid = '0;
    for (int n = 0; n < 3; n++) begin
      step(ro, re, so, se, acc);
      tests++;
      if (so[19] !== se[19] || (se[19] && so[18:0] !== se[18:0])) begin
        fails++;
        $display("FAIL contention_drain: got %h expected %h", so, se);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] ro, re;
    logic [19:0]     so, se, snap;
    int              acc, nacc, npop;
    nacc = 0;
    npop = 0;
    snap = '0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0010;
    for (int n = 0; n < 5; n++) begin
      step(ro, re, so, se, acc);
      if ((ro & 4'b0010) != '0) nacc++;
      tests++;
      if (ro !== re) begin
        fails++;
        $display("FAIL bp_ready: cycle %0d got %b expected %b", n, ro, re);
      end
      if (n == 2) snap = so;
      if (n > 2) begin
        tests++;
        if (so !== snap || so[19] !== 1'b1) begin
          fails++;
          $display("FAIL bp_stable: got %h expected %h", so, snap);
        end
      end
    end
    tests++;
    if (nacc != 2 || ro !== '0) begin
      fails++;
      $display("FAIL bp_accepts: got %0d accepts last ready=%b expected 2 and 0000", nacc, ro);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step(ro, re, so, se, acc);
      if (so[19]) npop++;
      tests++;
      if (so[19] !== se[19] || (se[19] && so[18:0] !== se[18:0])) begin
        fails++;
        $display("FAIL bp_drain: got %h expected %h", so, se);
      end
    end
    tests++;
    if (npop != 2) begin
      fails++;
      $display("FAIL bp_drain_count: got %0d expected 2", npop);
    end
  endtask

  task automatic test_reset_mid_flight();
    logic [NREQ-1:0] ro, re;
    logic [19:0]     so, se;
    int              acc;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1000;
    for (int n = 0; n < 3; n++) step(ro, re, so, se, acc);
    tests++;
    if (busy !== 1'b1 || bus.rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL rmf_full: got busy=%b rsp_valid=%b expected 1/1", busy, bus.rsp_valid);
    end
    rst = 1'b1;
    exp_q.delete();
    model_ptr = 0;
    #1;
    tests++;
    if ({bus.rsp_valid, busy, bus.req_ready} !== '0) begin
      fails++;
      $display("FAIL rmf_clear: got rsp_valid=%b busy=%b ready=%b expected 0", bus.rsp_valid, busy, bus.req_ready);
    end
    #1 rst = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    step(ro, re, so, se, acc);
    bus.req_valid = '0;
    tests++;
    if (ro !== 4'b0001) begin
      fails++;
      $display("FAIL rmf_first_grant: got %b expected 0001", ro);
    end
    for (int n = 0; n < 3; n++) begin
      step(ro, re, so, se, acc);
      tests++;
      if (so[19] !== se[19] || (se[19] && so[18:0] !== se[18:0])) begin
        fails++;
        $display("FAIL rmf_drain: got %h expected %h", so, se);
      end
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] ro, re;
    logic [19:0]     so, se;
    int              acc;
    do_reset();
    bus.req_valid = '0;
    for (int n = 0; n < 300; n++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step(ro, re, so, se, acc);
      tests++;
      if (ro !== re) begin
        fails++;
        $display("FAIL rand_ready: cycle %0d got %b expected %b", n, ro, re);
      end
      tests++;
      if (so[19] !== se[19] || (se[19] && so[18:0] !== se[18:0])) begin
        fails++;
        $display("FAIL rand_rsp: cycle %0d got %h expected %h", n, so, se);
      end
      if (acc >= 0) bus.req_valid[acc] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) bus.req_valid[i] = 1'b1;
      end
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step(ro, re, so, se, acc);
      tests++;
      if (so[19] !== se[19] || (se[19] && so[18:0] !== se[18:0])) begin
        fails++;
        $display("FAIL rand_drain: got %h expected %h", so, se);
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rand_leftover: got %0d outstanding expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single(0, 16'hFFFF, 16'h0001, 1'b0, {1'b1, 16'h0000, 2'd0}, "single_op");
    test_single(3, 16'h7FFF, 16'h0000, 1'b1, {1'b0, 16'h8000, 2'd3}, "carry_in");
    test_back_to_back();
    test_contention();
    test_backpressure();
    test_reset_mid_flight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
